// File: rtl/xor_stream_decrypt.sv
// Receive-side XOR stream decryptor: ciphertext XOR Galois-LFSR keystream.
// Valid/ready on both sides with one registered plaintext stage.
module xor_stream_decrypt #(
  parameter logic [7:0] TAPS         = 8'hB8,
  parameter logic [7:0] DEFAULT_SEED = 8'hA5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        key_load,
  input  logic [7:0]  key_in,
  input  logic        ct_valid,
  output logic        ct_ready,
  input  logic [7:0]  ct_data,
  output logic        pt_valid,
  input  logic        pt_ready,
  output logic [7:0]  pt_data,
  output logic        keyed,
  output logic [15:0] byte_count
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t      state_q;
  logic [7:0]  lfsr_q;
  logic [7:0]  lfsr_d;
  logic [7:0]  seed;
  logic        pt_valid_q;
  logic [7:0]  pt_data_q;
  logic [15:0] cnt_q;
  logic        accept;

  // A zero key would freeze the LFSR, so it is replaced.
  assign seed   = (key_in == 8'h00) ? DEFAULT_SEED : key_in;
  assign lfsr_d = {1'b0, lfsr_q[7:1]} ^ (lfsr_q[0] ? TAPS : 8'h00);

  assign ct_ready = (state_q == RUN) & ~key_load
                  & (~pt_valid_q | pt_ready);
  assign accept   = ct_valid & ct_ready;

  assign pt_valid   = pt_valid_q;
  assign pt_data    = pt_data_q;
  assign keyed      = (state_q == RUN);
  assign byte_count = cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      lfsr_q     <= DEFAULT_SEED;
      pt_valid_q <= 1'b0;
      pt_data_q  <= 8'h00;
      cnt_q      <= 16'h0000;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (key_load) begin
            state_q    <= RUN;
            lfsr_q     <= seed;
            pt_valid_q <= 1'b0;
            cnt_q      <= 16'h0000;
          end
        end
        RUN: begin
          if (key_load) begin
            lfsr_q     <= seed;
            pt_valid_q <= 1'b0;
            cnt_q      <= 16'h0000;
          end else if (accept) begin
            pt_data_q  <= ct_data ^ lfsr_q;
            pt_valid_q <= 1'b1;
            cnt_q      <= cnt_q + 16'd1;
            lfsr_q     <= lfsr_d;
          end else if (pt_ready) begin
            pt_valid_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
